adder100_serial_frontend: RTL and testbench

- Operand loader and result serialiser for the 100-bit combinational adder.
- Accepts operands A and B over a narrow 20-bit valid/ready stream and drives them, with Cin, into the adder's A/B/Cin inputs.
- Captures {Cout, Sum} from the adder, then streams the 100-bit result back out as 20-bit words with a last flag and carry flag.
- Sits directly upstream and downstream of the adder instance; the adder itself is instantiated outside this block.

---
 rtl/adder100_serial_frontend.sv | 155 +++++++++++++++
 tb/tb_adder100_serial_frontend.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adder100_serial_frontend.sv
// Operand loader and result serialiser wrapped around an external 100-bit adder.
// A then B arrive as narrow words (LS word first); {Cout,Sum} is captured once and streamed back out.
module adder100_serial_frontend #(
    parameter int WORD_W    = 20,
    parameter int NUM_WORDS = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_cin,
    output logic [WORD_W*NUM_WORDS-1:0]   add_a,
    output logic [WORD_W*NUM_WORDS-1:0]   add_b,
    output logic                          add_cin,
    input  logic [WORD_W*NUM_WORDS-1:0]   add_sum,
    input  logic                          add_cout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          out_carry,
    output logic                          busy
);

    localparam int DATA_W = WORD_W * NUM_WORDS;
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_CAPTURE,
        S_SEND
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [DATA_W-1:0]  r_add_a;
    logic [DATA_W-1:0]  r_add_b;
    logic               r_cin;
    logic [DATA_W:0]    r_result;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_last_idx;
    logic               w_wr_a;
    logic               w_wr_b;
    logic [WORD_W-1:0]  w_res_words [NUM_WORDS];

    assign w_last_idx = (r_idx == LAST_IDX);
    assign w_wr_a     = (r_state == S_LOAD_A) && in_valid;
    assign w_wr_b     = (r_state == S_LOAD_B) && in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD_A;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Index only moves on a handshake; everything else holds.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (w_last_idx) begin
                        w_state_next = S_LOAD_B;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            S_LOAD_B: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (w_last_idx) begin
                        w_state_next = S_CAPTURE;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                w_state_next = S_SEND;
                w_idx_next   = '0;
            end
            S_SEND: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    if (w_last_idx) begin
                        w_state_next = S_LOAD_A;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_LOAD_A;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_add_a  <= '0;
            r_add_b  <= '0;
            r_cin    <= 1'b0;
            r_result <= '0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (w_wr_a && (r_idx == IDX_W'(i)))
                    r_add_a[i*WORD_W +: WORD_W] <= in_data;
                if (w_wr_b && (r_idx == IDX_W'(i)))
                    r_add_b[i*WORD_W +: WORD_W] <= in_data;
            end
            if (w_wr_a && (r_idx == '0))
                r_cin <= in_cin;
            // The adder is combinational; its output is only trusted here.
            if (r_state == S_CAPTURE)
                r_result <= {add_cout, add_sum};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_res_words
            assign w_res_words[gi] = r_result[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? w_res_words[r_idx] : '0;
    assign out_last  = w_out_valid && w_last_idx;
    assign out_carry = w_out_valid && w_last_idx && r_result[DATA_W];
    assign busy      = !((r_state == S_LOAD_A) && (r_idx == '0));
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_cin;

endmodule

// File: tb/tb_adder100_serial_frontend.sv
// Bench for adder100_serial_frontend: behavioural 100-bit adder in the loop, directed table
// plus random transactions, gaps, output backpressure and mid-operation reset.
module tb_adder100_serial_frontend;

    localparam int W  = 20;
    localparam int N  = 5;
    localparam int DW = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_cin;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic          add_cin;
    logic [DW-1:0] add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_carry;
    logic          busy;

    adder100_serial_frontend #(.WORD_W(W), .NUM_WORDS(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_carry(out_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          cin;
        int            gap;
        int            stall_beat;
        logic [DW:0]   res;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Only word 0 carries the real cin; the others drive its inverse to show it is ignored.
    task automatic send_word(input logic [W-1:0] d, input logic c, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_ops(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic cin, input int gap, input int nb);
        for (int k = 0; k < N; k++)
            send_word(a[k*W +: W], (k == 0) ? cin : ~cin, gap);
        for (int k = 0; k < nb; k++)
            send_word(b[k*W +: W], ~cin, gap);
    endtask

    task automatic run_tx(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic cin, input int gap, input int stall_beat, input logic [DW:0] res);
        int t;
        logic [W-1:0] held;
        load_ops(a, b, cin, gap, N);
        chk({tag, " capture in_ready"}, in_ready, 0);
        chk({tag, " capture out_valid"}, out_valid, 0);
        chk({tag, " add_cin"}, add_cin, cin);
        chk({tag, " add_a"}, add_a, a);
        chk({tag, " add_b"}, add_b, b);
        for (int k = 0; k < N; k++) begin
            t = 0;
            while (!out_valid && t < 20) begin
                tick();
                t++;
            end
            if (!out_valid) begin
                n_checks++;
                $display("FAIL %s out_valid timeout beat %0d: got 0 expected 1", tag, k);
                return;
            end
            if (k == 0) chk({tag, " latency"}, t, 1);
            chk({tag, $sformatf(" data beat%0d", k)}, out_data, res[k*W +: W]);
            chk({tag, $sformatf(" last beat%0d", k)}, out_last, (k == N-1));
            chk({tag, $sformatf(" carry beat%0d", k)}, out_carry, (k == N-1) ? res[DW] : 1'b0);
            if (k == stall_beat) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 20'hABCDE;
                held      = out_data;
                repeat (3) begin
                    tick();
                    chk({tag, " stall data"}, out_data, held);
                    chk({tag, " stall valid"}, out_valid, 1);
                    chk({tag, " stall in_ready"}, in_ready, 0);
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            tick();
        end
        chk({tag, " done out_valid"}, out_valid, 0);
        chk({tag, " done busy"}, busy, 0);
        chk({tag, " done in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [127:0] ra, rb;
        logic         rc;
        logic [DW:0]  rres;
        int           seen;

        tbl[0] = '{a: 100'd1, b: 100'd1, cin: 1'b0, gap: 2, stall_beat: 1, res: 101'd2};
        tbl[1] = '{a: {DW{1'b1}}, b: 100'd0, cin: 1'b1, gap: 0, stall_beat: -1, res: {1'b1, {DW{1'b0}}}};
        tbl[2] = '{a: {DW{1'b1}}, b: {DW{1'b1}}, cin: 1'b1, gap: 1, stall_beat: 4, res: {(DW+1){1'b1}}};
        tbl[3] = '{a: {25{4'h5}}, b: {25{4'hA}}, cin: 1'b1, gap: 0, stall_beat: -1, res: {1'b1, {DW{1'b0}}}};
        tbl[4] = '{a: 100'd0, b: 100'd0, cin: 1'b1, gap: 0, stall_beat: 0, res: 101'd1};
        tbl[5] = '{a: 100'hFFFFF, b: 100'd1, cin: 1'b0, gap: 0, stall_beat: -1, res: 101'h100000};

        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 20'h00005;
        in_cin    = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst out_carry", out_carry, 0);
        chk("rst out_data", out_data, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst add_a", add_a, 0);
        chk("rst add_b", add_b, 0);
        chk("rst add_cin", add_cin, 0);

        send_word(20'h12345, 1'b1, 0);
        chk("busy after word0", busy, 1);
        chk("add_a word0", add_a, 100'h12345);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_tx($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                   tbl[i].gap, tbl[i].stall_beat, tbl[i].res);

        for (int i = 0; i < 30; i++) begin
            ra   = {$urandom, $urandom, $urandom, $urandom};
            rb   = {$urandom, $urandom, $urandom, $urandom};
            rc   = 1'($urandom_range(0, 1));
            rres = {1'b0, ra[DW-1:0]} + {1'b0, rb[DW-1:0]} + {{DW{1'b0}}, rc};
            run_tx($sformatf("rnd%0d", i), ra[DW-1:0], rb[DW-1:0], rc, 0, -1, rres);
        end

        load_ops({DW{1'b1}}, {DW{1'b1}}, 1'b1, 0, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst add_a", add_a, 0);
        chk("midrst add_b", add_b, 0);
        chk("midrst add_cin", add_cin, 0);
        chk("midrst busy", busy, 0);
        seen = 0;
        repeat (20) begin
            if (out_valid) seen = 1;
            tick();
        end
        chk("midrst no out_valid", seen, 0);
        run_tx("postrst", {25{4'h5}}, {25{4'hA}}, 1'b1, 0, -1, {1'b1, {DW{1'b0}}});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
